// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the shared down-timer arbiter.
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    // Widest request vector the helpers accept; NUM_REQ must not exceed this.
    localparam int unsigned MAX_REQ = 32;

    // Round-robin pick: first set bit searching upward from (last+1) mod n, with wrap.
    // Returns last when nothing is requested.
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        last,
        input int unsigned        n
    );
        int unsigned idx;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (!found && req[idx]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/loadable_down_counter.sv
// Loadable down counter that saturates at zero.
module loadable_down_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          zero
);

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Zero flag for the controlling FSM.
    always_comb begin
        zero = (count == '0);
    end

endmodule

// File: rtl/shared_down_timer_arbiter.sv
// One shared down counter, handed round-robin to NUM_REQ requesters.
module shared_down_timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MOD_VALUE = 256
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [NUM_REQ*$clog2(MOD_VALUE)-1:0]    load_val,
    input  logic                                    abort,
    output logic [NUM_REQ-1:0]                      grant,
    output logic [NUM_REQ-1:0]                      done,
    output logic                                    busy,
    output logic [$clog2(MOD_VALUE)-1:0]            count
);

    localparam int unsigned CW = $clog2(MOD_VALUE);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   win;
    logic [NUM_REQ-1:0] win_oh;
    logic [CW-1:0]   win_val;
    logic            cnt_load;
    logic [CW-1:0]   cnt_val;
    logic            cnt_en;
    logic            cnt_zero;

    // Arbitration result for the current request vector.
    always_comb begin
        win     = IW'(rr_pick(MAX_REQ'(req), 32'(last), NUM_REQ));
        win_oh  = NUM_REQ'(onehot(32'(win)));
        win_val = load_val[win*CW +: CW];
    end

    // Counter control: abort reuses the load path to clear the count to zero.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
        case (state)
            IDLE: begin
                cnt_load = |req;
                cnt_val  = win_val;
            end
            COUNT: begin
                cnt_load = abort;
                cnt_en   = !abort;
            end
            default: ;
        endcase
    end

    loadable_down_counter #(
        .CW(CW)
    ) u_counter (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .count    (count),
        .zero     (cnt_zero)
    );

    // Control FSM with registered grant/done/busy and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            last  <= IW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        grant <= win_oh;
                        busy  <= 1'b1;
                        last  <= win;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        done  <= grant;
                        state <= DONE;
                    end
                end
                DONE: begin
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_down_timer_arbiter.sv
// Directed scoreboard bench for shared_down_timer_arbiter.
module tb_shared_down_timer_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned MODV = 256;
    localparam int unsigned CW   = 8;

    logic               clk;
    logic               rstn;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] load_val;
    logic               abort;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      count;

    typedef struct {
        string           tag;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] d;
        logic            b;
        logic [CW-1:0]   c;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    shared_down_timer_arbiter #(
        .NUM_REQ   (NREQ),
        .MOD_VALUE (MODV)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .load_val (load_val),
        .abort    (abort),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string tag, input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                              input logic b, input logic [CW-1:0] c);
        exp_t e;
        e.tag = tag; e.g = g; e.d = d; e.b = b; e.c = c;
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = q.pop_front();
        checks++;
        assert (grant === e.g) else begin
            failures++;
            $error("FAIL %s grant: got %b expected %b", e.tag, grant, e.g);
        end
        checks++;
        assert (done === e.d) else begin
            failures++;
            $error("FAIL %s done: got %b expected %b", e.tag, done, e.d);
        end
        checks++;
        assert (busy === e.b) else begin
            failures++;
            $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.b);
        end
        checks++;
        assert (count === e.c) else begin
            failures++;
            $error("FAIL %s count: got %0d expected %0d", e.tag, count, e.c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock per queued expectation, compared just after the edge.
    task automatic run_check();
        while (q.size() != 0) begin
            tick();
            pop_check();
        end
    endtask

    task automatic set_lv(input int unsigned i, input logic [CW-1:0] v);
        load_val[i*CW +: CW] = v;
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        req  = '0;
        abort = 1'b0;
        #3;
        expect_out(tag, '0, '0, 1'b0, '0);
        pop_check();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn     = 1'b0;
        req      = '0;
        abort    = 1'b0;
        load_val = '0;
        #12;
        do_reset("reset");

        // Single request, load 3.
        set_lv(0, 8'd3);
        req = 4'b0001;
        expect_out("single_E", 4'b0001, 4'b0000, 1'b1, 8'd3);
        run_check();
        req = '0;
        expect_out("single_E1", 4'b0001, 4'b0000, 1'b1, 8'd2);
        expect_out("single_E2", 4'b0001, 4'b0000, 1'b1, 8'd1);
        expect_out("single_E3", 4'b0001, 4'b0000, 1'b1, 8'd0);
        expect_out("single_done", 4'b0001, 4'b0001, 1'b1, 8'd0);
        expect_out("single_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
        expect_out("single_idle2", 4'b0000, 4'b0000, 1'b0, 8'd0);
        run_check();

        // Zero load on requester 2.
        set_lv(2, 8'd0);
        req = 4'b0100;
        expect_out("zero_E", 4'b0100, 4'b0000, 1'b1, 8'd0);
        run_check();
        req = '0;
        expect_out("zero_done", 4'b0100, 4'b0100, 1'b1, 8'd0);
        expect_out("zero_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
        run_check();

        // Fairness from a fresh pointer: 0,1,2,3,0.
        do_reset("reset_fair");
        for (int i = 0; i < 4; i++) set_lv(i, 8'd2);
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            logic [NREQ-1:0] g;
            g = 4'b0001 << (r % 4);
            expect_out($sformatf("fair%0d_E", r),    g, 4'b0000, 1'b1, 8'd2);
            expect_out($sformatf("fair%0d_E1", r),   g, 4'b0000, 1'b1, 8'd1);
            expect_out($sformatf("fair%0d_E2", r),   g, 4'b0000, 1'b1, 8'd0);
            expect_out($sformatf("fair%0d_done", r), g, g,       1'b1, 8'd0);
            expect_out($sformatf("fair%0d_idle", r), 4'b0000, 4'b0000, 1'b0, 8'd0);
        end
        run_check();
        req = '0;

        // Abort at count 6; pointer still advanced to requester 1.
        set_lv(1, 8'd10);
        req = 4'b0010;
        expect_out("abort_E", 4'b0010, 4'b0000, 1'b1, 8'd10);
        run_check();
        req = '0;
        for (int k = 9; k >= 6; k--)
            expect_out($sformatf("abort_c%0d", k), 4'b0010, 4'b0000, 1'b1, CW'(k));
        run_check();
        abort = 1'b1;
        expect_out("abort_cleared", 4'b0000, 4'b0000, 1'b0, 8'd0);
        run_check();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) set_lv(i, 8'd5);
        req = 4'b1111;
        expect_out("after_abort_grant", 4'b0100, 4'b0000, 1'b1, 8'd5);
        run_check();

        // Asynchronous reset mid-run with count 5.
        req = 4'b1010;
        #1;
        rstn = 1'b0;
        expect_out("async_reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
        #1;
        pop_check();
        @(negedge clk);
        rstn = 1'b1;
        expect_out("post_reset_grant", 4'b0010, 4'b0000, 1'b1, 8'd5);
        run_check();
        req = '0;

        // Maximum load, request dropped mid-run.
        do_reset("reset_max");
        set_lv(0, 8'd255);
        req = 4'b0001;
        for (int k = 0; k <= 100; k++)
            expect_out($sformatf("max_k%0d", k), 4'b0001, 4'b0000, 1'b1, CW'(255 - k));
        run_check();
        req = '0;
        for (int k = 101; k <= 255; k++)
            expect_out($sformatf("max_k%0d", k), 4'b0001, 4'b0000, 1'b1, CW'(255 - k));
        expect_out("max_done", 4'b0001, 4'b0001, 1'b1, 8'd0);
        expect_out("max_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
        expect_out("max_idle2", 4'b0000, 4'b0000, 1'b0, 8'd0);
        run_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_down_timer_arbiter.md
Name: shared_down_timer_arbiter

Overview:
Shares one loadable down counter among NUM_REQ requesters that each need a timed delay.
- Arbitrates requests round-robin and loads the winner's delay value.
- Counts down to zero, then returns a one-cycle done pulse to the winner.
- Sits between requesting control FSMs and the down-counter datapath, so each client does not need its own counter.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- MOD_VALUE, 256, counter modulus; CW = $clog2(MOD_VALUE) is the count width; legal load values are 0..MOD_VALUE-1.

Ports:
- clk  in  1  single system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester; sampled only in IDLE.
- load_val  in  NUM_REQ*CW  per-requester delay; requester i uses bits [i*CW +: CW]; sampled with req.
- abort  in  1  cancels the active timing run.
- grant  out  NUM_REQ  one-hot owner of the counter; all zero when idle.
- done  out  NUM_REQ  one-cycle pulse on the winner's bit when its count expires.
- busy  out  1  high while grant is non-zero.
- count  out  CW  current counter value.

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; grant, done, busy and count = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has highest priority after reset.
- States are IDLE, COUNT and DONE. All outputs are registered.
- IDLE:
  - If req != 0 at edge E, the winner w is the first set bit searching from (last+1) mod NUM_REQ upward with wrap.
  - At edge E: grant = onehot(w), busy = 1, count = load_val[w], last = w, state goes to COUNT.
  - If req == 0, the block stays in IDLE and count holds 0.
- COUNT:
  - At each edge: if count != 0, count decrements by 1; if count == 0, state goes to DONE and done[w] = 1.
  - Latency: done is high in the cycle after edge E+L+1, where L is the loaded value.
  - L = 0 is legal and gives done after edge E+1; there is no special case.
- DONE:
  - done[w] is high for exactly one cycle and grant is still held.
  - At the next edge: grant = 0, busy = 0, done = 0, state goes to IDLE.
  - This forces at least one IDLE cycle between runs; arbitration for the next run happens in that IDLE cycle.
- Requests:
  - Dropping req[w] during COUNT has no effect; the run completes and done still pulses.
  - req and load_val are ignored outside IDLE.
- Abort:
  - abort high at an edge while in COUNT forces IDLE: grant = 0, busy = 0, count = 0, no done pulse, last still updated.
  - abort is ignored in IDLE and DONE.
- Reset mid-operation:
  - Outputs clear immediately (asynchronous) and no done is emitted.
  - Arbitration restarts from requester 0.
- Wrap-around:
  - The counter never decrements below 0, so there is no underflow wrap.
  - The pointer wraps from NUM_REQ-1 to 0.
- Invariants: done is only ever set on a bit where grant is set; grant is always one-hot or zero.

Decomposition:
- Shared package timer_arb_pkg holds:
  - State enum state_t {IDLE, COUNT, DONE}.
  - Function rr_pick(req, last) returning the winner index.
  - Function onehot(idx).
- Natural sub-module: loadable_down_counter (clk, rstn, load, load_val, en, count, zero), which is reusable by the counter library.
- The top level holds the FSM, the round-robin pointer and the done/grant registers.

Test Plan:
- Single request: req = 0001, load_val[0] = 3 sampled at edge E → grant = 0001 after E; count steps 3,2,1,0; done = 0001 for one cycle after E+4; busy drops after E+5.
- Zero load: req = 0100, load_val[2] = 0 → done = 0100 one cycle after E+1; count stays 0 throughout.
- Fairness: req = 1111 held, all loads = 2 → grant order 0,1,2,3,0 with one IDLE cycle between runs; each done matches its grant.
- Abort: req = 0010, load_val = 10, abort pulsed when count = 6 → grant = 0 and count = 0 next cycle, no done; the next request with req = 1111 is granted to requester 2.
- Asynchronous reset while count = 5 → outputs clear immediately; after release with req = 1010, grant goes to requester 1 (pointer reset).
- Maximum value with MOD_VALUE = 256, load 255 → count 255..0 with no underflow; done exactly 256 edges after E; req withdrawn mid-run still yields done.
